// File: rtl/dma_pkg.sv
// Shared types and default widths for the memory copy/fill DMA.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dma_pkg;

  localparam int DMA_ADDR_W = 8;
  localparam int DMA_DATA_W = 8;

  // RD is only visited in copy mode; fill mode loops WR -> WR.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    FIN  = 2'd3
  } dma_state_e;

endpackage

// File: rtl/mem_copy_dma.sv
// Purpose: block copy (src -> dst, ascending) or constant fill of a memory region over the data-memory port.
// Latency: copy of N bytes -> done k+2N+1, fill -> k+N+1, length 0 -> k+1 (start sampled at edge k).
// Backpressure: none; memory is assumed single-cycle. abort ends the transfer after the current bus cycle.
//
// Ports:
//   clk, rst_n                 clock and async active-low reset
//   start, mode_fill           one-cycle request (IDLE only); 0 = copy, 1 = fill
//   src_addr, dst_addr, length transfer parameters, latched on an accepted start
//   fill_value                 byte written in fill mode, latched on an accepted start
//   abort                      ends the transfer early (RD/WR only)
//   busy, done, aborted        status: not-IDLE, one-cycle FIN pulse, sticky abort flag
//   bytes_left                 bytes still to be written
//   mem_*                      data-memory port; outputs decoded from registered state
module mem_copy_dma
  import dma_pkg::*;
#(
  parameter int ADDR_W = DMA_ADDR_W,
  parameter int DATA_W = DMA_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode_fill,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic [DATA_W-1:0] fill_value,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [ADDR_W-1:0] bytes_left,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_read_data
);

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  dma_state_e        state_q;
  logic              fill_q;
  logic              aborted_q;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [ADDR_W-1:0] left_q;
  logic [DATA_W-1:0] fill_val_q;
  logic [DATA_W-1:0] buf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fill_q     <= 1'b0;
      aborted_q  <= 1'b0;
      src_q      <= '0;
      dst_q      <= '0;
      left_q     <= '0;
      fill_val_q <= '0;
      buf_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // abort is ignored here, so start always wins when both are high.
          if (start) begin
            fill_q     <= mode_fill;
            src_q      <= src_addr;
            dst_q      <= dst_addr;
            left_q     <= length;
            fill_val_q <= fill_value;
            aborted_q  <= 1'b0;
            if (length == '0) begin
              state_q <= FIN;
            end else if (mode_fill) begin
              state_q <= WR;
            end else begin
              state_q <= RD;
            end
          end
        end

        RD: begin
          // The read in flight always completes, even when aborting.
          buf_q <= mem_read_data;
          src_q <= src_q + ONE;
          if (abort) begin
            aborted_q <= 1'b1;
            state_q   <= FIN;
          end else begin
            state_q <= WR;
          end
        end

        WR: begin
          // The write is committed by memory on this edge regardless of abort,
          // so the counters advance either way.
          dst_q  <= dst_q + ONE;
          left_q <= left_q - ONE;
          if (abort) begin
            aborted_q <= 1'b1;
            state_q   <= FIN;
          end else if (left_q == ONE) begin
            state_q <= FIN;
          end else if (fill_q) begin
            state_q <= WR;
          end else begin
            state_q <= RD;
          end
        end

        FIN: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Bus outputs are pure decodes of registered state, so an asynchronous
  // reset removes any pending read/write immediately.
  assign busy           = (state_q != IDLE);
  assign done           = (state_q == FIN);
  assign aborted        = aborted_q;
  assign bytes_left     = left_q;
  assign mem_read       = (state_q == RD);
  assign mem_write      = (state_q == WR);
  assign mem_address    = (state_q == RD) ? src_q :
                          (state_q == WR) ? dst_q : '0;
  assign mem_write_data = (state_q == WR) ? (fill_q ? fill_val_q : buf_q) : '0;

endmodule

// File: tb/tb_mem_copy_dma.sv
module tb_mem_copy_dma;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       mode_fill = 1'b0;
  logic [7:0] src_addr = '0;
  logic [7:0] dst_addr = '0;
  logic [7:0] length = '0;
  logic [7:0] fill_value = '0;
  logic       abort = 1'b0;
  logic       busy;
  logic       done;
  logic       aborted;
  logic [7:0] bytes_left;
  logic [7:0] mem_address;
  logic [7:0] mem_write_data;
  logic       mem_write;
  logic       mem_read;
  logic [7:0] mem_read_data;

  always #5 clk = ~clk;

  mem_copy_dma #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .mode_fill      (mode_fill),
    .src_addr       (src_addr),
    .dst_addr       (dst_addr),
    .length         (length),
    .fill_value     (fill_value),
    .abort          (abort),
    .busy           (busy),
    .done           (done),
    .aborted        (aborted),
    .bytes_left     (bytes_left),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_write      (mem_write),
    .mem_read       (mem_read),
    .mem_read_data  (mem_read_data)
  );

  // Memory model: combinational read, write committed on the clock edge.
  // Bench preloads share the same process so the array has one writer.
  logic [7:0] mem [256];
  logic       clr = 1'b0;
  logic       pl_we = 1'b0;
  logic [7:0] pl_addr = '0;
  logic [7:0] pl_dat = '0;

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (mem_write) begin
      mem[mem_address] <= mem_write_data;
    end else if (pl_we) begin
      mem[pl_addr] <= pl_dat;
    end
  end

  assign mem_read_data = mem_read ? mem[mem_address] : 8'hzz;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_we = 1'b1; pl_addr = a; pl_dat = d;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  logic [7:0] rd_log[$];
  logic [7:0] wr_log[$];

  // Issues a start and samples every following cycle until done. lat is the
  // cycle offset of done from the start edge (0 if done never came).
  task automatic run(input logic mf, input logic [7:0] s, input logic [7:0] d,
                     input logic [7:0] l, input logic [7:0] fv, input int abort_wr,
                     output int lat, output int busy_cyc);
    rd_log.delete();
    wr_log.delete();
    @(negedge clk);
    mode_fill = mf; src_addr = s; dst_addr = d; length = l; fill_value = fv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    busy_cyc = 0;
    for (int c = 1; c <= 600; c++) begin
      if (busy) busy_cyc++;
      if (mem_read) rd_log.push_back(mem_address);
      if (mem_write) wr_log.push_back(mem_address);
      abort = (abort_wr > 0) && mem_write && (wr_log.size() == abort_wr);
      if (done) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
    abort = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int bc;
    int c;

    // ---------------- reset state ----------------
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_aborted", aborted, 0);
    check("rst_bus", {mem_read, mem_write, mem_address, mem_write_data}, 0);
    check("rst_left", bytes_left, 0);
    rst_n = 1'b1;

    // ---------------- copy 4 bytes ----------------
    preload(8'h10, 8'hA1);
    preload(8'h11, 8'hB2);
    preload(8'h12, 8'hC3);
    preload(8'h13, 8'hD4);
    run(1'b0, 8'h10, 8'h80, 8'd4, 8'h00, 0, lat, bc);
    check("cp_lat", lat, 9);
    check("cp_busy_cycles", bc, 9);
    check("cp_nrd", rd_log.size(), 4);
    check("cp_nwr", wr_log.size(), 4);
    check("cp_left_fin", bytes_left, 0);
    @(negedge clk);
    check("cp_m80", mem[8'h80], 8'hA1);
    check("cp_m81", mem[8'h81], 8'hB2);
    check("cp_m82", mem[8'h82], 8'hC3);
    check("cp_m83", mem[8'h83], 8'hD4);
    check("cp_idle", {busy, done, aborted}, 0);

    // ---------------- fill 3 bytes ----------------
    run(1'b1, 8'h00, 8'h20, 8'd3, 8'h5A, 0, lat, bc);
    check("fl_lat", lat, 4);
    check("fl_nrd", rd_log.size(), 0);
    check("fl_nwr", wr_log.size(), 3);
    @(negedge clk);
    check("fl_m20", mem[8'h20], 8'h5A);
    check("fl_m21", mem[8'h21], 8'h5A);
    check("fl_m22", mem[8'h22], 8'h5A);
    check("fl_m23", mem[8'h23], 8'h00);

    // ---------------- address wrap ----------------
    preload(8'hFE, 8'h11);
    preload(8'hFF, 8'h22);
    preload(8'h00, 8'h33);
    preload(8'h01, 8'h44);
    run(1'b0, 8'hFE, 8'h02, 8'd4, 8'h00, 0, lat, bc);
    check("wr_lat", lat, 9);
    check("wr_nrd", rd_log.size(), 4);
    check("wr_rd0", rd_log[0], 8'hFE);
    check("wr_rd1", rd_log[1], 8'hFF);
    check("wr_rd2", rd_log[2], 8'h00);
    check("wr_rd3", rd_log[3], 8'h01);
    check("wr_wa0", wr_log[0], 8'h02);
    check("wr_wa3", wr_log[3], 8'h05);
    @(negedge clk);
    check("wr_mem", {mem[2], mem[3], mem[4], mem[5]}, 32'h11223344);

    run(1'b1, 8'h00, 8'hFF, 8'd2, 8'h77, 0, lat, bc);
    check("wf_lat", lat, 3);
    check("wf_nwr", wr_log.size(), 2);
    check("wf_wa0", wr_log[0], 8'hFF);
    check("wf_wa1", wr_log[1], 8'h00);
    @(negedge clk);
    check("wf_mem", {mem[8'hFF], mem[8'h00]}, 16'h7777);

    // ---------------- length 0 ----------------
    run(1'b0, 8'h10, 8'h90, 8'd0, 8'h00, 0, lat, bc);
    check("z_lat", lat, 1);
    check("z_bus", rd_log.size() + wr_log.size(), 0);
    @(negedge clk);
    check("z_idle", busy, 0);

    // ---------------- start while busy ----------------
    @(negedge clk);
    mode_fill = 1'b0; src_addr = 8'h10; dst_addr = 8'h50; length = 8'd3;
    start = 1'b1;
    @(negedge clk);                       // cycle k+1: RD
    start = 1'b1; length = 8'h77; mode_fill = 1'b1; dst_addr = 8'hE0;
    @(negedge clk);                       // cycle k+2: WR
    start = 1'b0;
    check("sb_left", bytes_left, 3);
    check("sb_wr", {mem_write, mem_address, mem_write_data}, {1'b1, 8'h50, 8'hA1});
    c = 2;
    while (!done && c < 100) begin
      @(negedge clk);
      c++;
    end
    check("sb_lat", c, 7);
    @(negedge clk);
    check("sb_mem", {mem[8'h50], mem[8'h51], mem[8'h52], mem[8'hE0]}, 32'hA1B2C300);

    // ---------------- abort in 2nd WR ----------------
    for (int i = 0; i < 8; i++) preload(8'h60 + 8'(i), 8'hC0 + 8'(i));
    run(1'b0, 8'h60, 8'hA0, 8'd8, 8'h00, 2, lat, bc);
    check("ab_lat", lat, 5);
    check("ab_nwr", wr_log.size(), 2);
    check("ab_flag", aborted, 1);
    check("ab_left", bytes_left, 6);
    @(negedge clk);
    check("ab_idle", {busy, done, aborted}, 3'b001);
    check("ab_left_idle", bytes_left, 6);
    check("ab_mem", {mem[8'hA0], mem[8'hA1], mem[8'hA2]}, 24'hC0C100);
    run(1'b0, 8'h00, 8'h00, 8'd0, 8'h00, 0, lat, bc);
    check("ab_clear", aborted, 0);

    // ---------------- reset mid-copy ----------------
    @(negedge clk);
    mode_fill = 1'b0; src_addr = 8'h10; dst_addr = 8'hB0; length = 8'd4;
    start = 1'b1;
    @(negedge clk);                       // RD
    start = 1'b0;
    @(negedge clk);                       // WR
    check("rm_inwr", mem_write, 1);
    rst_n = 1'b0;
    #1;
    check("rm_outs", {busy, done, aborted, mem_read, mem_write}, 0);
    check("rm_bus", {mem_address, mem_write_data, bytes_left}, 0);
    repeat (3) @(negedge clk);
    check("rm_nowrite", {mem[8'hB0], mem[8'hB1]}, 0);
    rst_n = 1'b1;
    run(1'b0, 8'h10, 8'hB0, 8'd4, 8'h00, 0, lat, bc);
    check("rm_lat", lat, 9);
    @(negedge clk);
    check("rm_mem", {mem[8'hB0], mem[8'hB1], mem[8'hB2], mem[8'hB3]}, 32'hA1B2C3D4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_copy_dma.md
Name: mem_copy_dma

Overview:
- Bus initiator that drives the processor data-memory port: address, write data, write strobe and read strobe.
- Copies a block of bytes from a source to a destination region (copy mode), or writes a constant value over a region (fill mode).
- Sits beside the CPU core. While it is busy it owns the data-memory port; the top level muxes the port on `busy`.

Parameters:
- ADDR_W, 8, width of memory address and of length/counters.
- DATA_W, 8, memory data width.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- mode_fill  input  1  0 = copy src→dst, 1 = fill dst with fill_value; latched at start.
- src_addr  input  ADDR_W  source base; latched at start.
- dst_addr  input  ADDR_W  destination base; latched at start.
- length  input  ADDR_W  byte count 0..255; latched at start.
- fill_value  input  DATA_W  fill byte; latched at start.
- abort  input  1  stop the transfer early.
- busy  output  1  high whenever the state is not IDLE.
- done  output  1  one-cycle pulse in FIN.
- aborted  output  1  sticky flag: last transfer ended by abort; cleared on the next accepted start.
- bytes_left  output  ADDR_W  bytes remaining to write.
- mem_address  output  ADDR_W  to memory address.
- mem_write_data  output  DATA_W  to memory write data.
- mem_write  output  1  memory write strobe; memory commits on the clk edge.
- mem_read  output  1  memory read strobe; read data is valid in the same cycle.
- mem_read_data  input  DATA_W  from memory; high-Z when mem_read=0, sampled only while mem_read=1.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE.
  - busy, done, aborted, mem_write and mem_read = 0.
  - mem_address, mem_write_data and bytes_left = 0.
  - Internal src/dst pointers and the data buffer = 0.
- Bus outputs are registered-state decoded. In IDLE and FIN: mem_read=0, mem_write=0, mem_address=0.
- States: IDLE, RD, WR, FIN.
- IDLE:
  - start=1 latches all inputs, clears aborted and sets bytes_left=length.
  - Next state: length==0 → FIN; mode_fill=1 → WR; otherwise → RD.
  - start while not IDLE is ignored and has no side effects.
- RD (copy mode only):
  - mem_read=1, mem_address=src pointer.
  - At the clock edge: buffer ← mem_read_data, src pointer +1, next state WR.
- WR:
  - mem_write=1, mem_address=dst pointer.
  - mem_write_data = buffer (copy) or fill_value (fill).
  - At the clock edge: dst pointer +1, bytes_left −1.
  - Next state: bytes_left==1 → FIN; else RD (copy) or WR (fill).
- FIN: done=1 for exactly one cycle, then IDLE.
- Latency, with start sampled at edge k:
  - Copy of N bytes: first RD in cycle k+1, done asserted in cycle k+2N+1.
  - Fill of N bytes: done in cycle k+N+1.
  - length=0: done in cycle k+1, with no bus activity.
- Pointer arithmetic is modulo 2^ADDR_W (address 255+1 wraps to 0).
- Copy is strictly ascending.
  - Overlapping regions with dst > src propagate already-copied bytes. This is defined behaviour; no backward copy is performed.
- abort=1 sampled in RD or WR:
  - The bus cycle currently asserted completes normally, i.e. a WR write is still committed.
  - Next state is FIN, aborted set to 1, bytes_left holds its post-edge value.
  - abort in IDLE or FIN has no effect.
  - start and abort together in IDLE: start wins.
- Reset asserted mid-transfer: immediate return to IDLE, all outputs at reset values, and no further memory writes.

Decomposition:
- Package `dma_pkg`: state enum (IDLE, RD, WR, FIN) and the ADDR_W/DATA_W defaults.
- No sub-module. The FSM, pointers and buffer fit in one module.

Test Plan:
- Copy: preload mem[0x10..0x13]=A1,B2,C3,D4; start src=0x10 dst=0x80 len=4 → mem[0x80..0x83]=A1,B2,C3,D4; done exactly 9 cycles after the start edge; busy high for 9 cycles.
- Fill: start mode_fill=1 dst=0x20 len=3 fill_value=0x5A → mem[0x20..0x22]=5A; mem_read never asserted; done 4 cycles after start.
- Wrap: copy src=0xFE dst=0x02 len=4 → reads addresses FE,FF,00,01 in order, writes 02..05; fill dst=0xFF len=2 → writes FF then 00.
- Boundaries:
  - length=0 → done 1 cycle after start, with no mem_read/mem_write.
  - A second start while busy is ignored; bytes_left is unchanged.
- Abort: copy len=8, assert abort in the 2nd WR cycle → exactly 2 bytes written, aborted=1, bytes_left=6, done pulses once, then IDLE. The next start clears aborted.
- Reset mid-copy: drop rst_n during a WR cycle → all outputs 0 immediately; no write is committed on the following edges; a new copy after release works correctly.
